pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined shifter/rotator with valid/ready handshakes on both sides.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right. Mode and amount are selectable per transaction.
- One register level per log2 shift stage, so it closes timing at wide WIDTH.
- Sits between operand-issue logic and a downstream consumer (ALU writeback / datapath FIFO).

---
 rtl/pipelined_barrel_shifter.sv | 156 +++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shifter/rotator: one register level per shift-amount bit, valid/ready on both sides.
// Stage i applies a 2^i shift when its shamt bit is set; a single global enable stalls every stage.
module pipelined_barrel_shifter #(
  parameter  int WIDTH       = 8,
  localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic [2:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_carry,
  output logic                   out_zero
);

  localparam int LATENCY = SHAMT_WIDTH;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sign,
    input int               s
  );
    logic [2*WIDTH-1:0] t;
    logic [WIDTH-1:0]   r;
    t = '0;
    r = d;
    case (op)
      OP_SLL: r = d << s;
      OP_SRL: r = d >> s;
      OP_SRA: begin
        t = {{WIDTH{sign}}, d} >> s;
        r = t[WIDTH-1:0];
      end
      OP_ROL: begin
        t = {d, d} << s;
        r = t[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        t = {d, d} >> s;
        r = t[WIDTH-1:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // The carry only depends on the original operand, so it is resolved once at accept.
  logic [SHAMT_WIDTH-1:0] shamt_m1;
  logic [WIDTH-1:0]       sll_probe;
  logic [WIDTH-1:0]       srl_probe;
  logic                   in_carry;

  assign shamt_m1  = in_shamt - SHAMT_WIDTH'(1);
  assign sll_probe = in_data << shamt_m1;
  assign srl_probe = in_data >> shamt_m1;

  always_comb begin
    in_carry = 1'b0;
    if (in_shamt != '0) begin
      case (in_op)
        OP_SLL:         in_carry = sll_probe[WIDTH-1];
        OP_SRL, OP_SRA: in_carry = srl_probe[0];
        default:        in_carry = 1'b0;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic                     valid_reg;
      logic                     carry_reg;
      logic [WIDTH-1:0]         data_reg;

      logic                     stage_valid;
      logic                     stage_carry;
      logic                     stage_sign;
      logic [WIDTH-1:0]         stage_data;
      logic [2:0]               stage_op;
      // Each stage only carries the shamt bits not yet consumed; bit 0 is its own.
      logic [SHAMT_WIDTH-gi-1:0] stage_shamt;
      logic [WIDTH-1:0]         shifted;

      if (gi == 0) begin : g_src
        assign stage_valid = in_valid;
        assign stage_carry = in_carry;
        assign stage_sign  = in_data[WIDTH-1];
        assign stage_data  = in_data;
        assign stage_op    = in_op;
        assign stage_shamt = in_shamt;
      end else begin : g_src
        assign stage_valid = g_stage[gi-1].valid_reg;
        assign stage_carry = g_stage[gi-1].carry_reg;
        assign stage_sign  = g_stage[gi-1].g_ctrl.sign_reg;
        assign stage_data  = g_stage[gi-1].data_reg;
        assign stage_op    = g_stage[gi-1].g_ctrl.op_reg;
        assign stage_shamt = g_stage[gi-1].g_ctrl.shamt_reg;
      end

      assign shifted = stage_shamt[0] ? shift_stage(stage_data, stage_op, stage_sign, 1 << gi)
                                      : stage_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          data_reg  <= '0;
        end else if (advance) begin
          valid_reg <= stage_valid;
          carry_reg <= stage_carry;
          data_reg  <= shifted;
        end
      end

      if (gi < LATENCY-1) begin : g_ctrl
        logic [2:0]                op_reg;
        logic                      sign_reg;
        logic [SHAMT_WIDTH-gi-2:0] shamt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            op_reg    <= '0;
            sign_reg  <= 1'b0;
            shamt_reg <= '0;
          end else if (advance) begin
            op_reg    <= stage_op;
            sign_reg  <= stage_sign;
            shamt_reg <= stage_shamt[SHAMT_WIDTH-gi-1:1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[LATENCY-1].valid_reg;
  assign out_data  = g_stage[LATENCY-1].data_reg;
  assign out_carry = g_stage[LATENCY-1].carry_reg;
  assign out_zero  = (out_data == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=8, three pipeline stages).
// Table-driven op/boundary vectors plus hand-written backpressure, bubble and reset sequences.
module tb_pipelined_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;

  int checks;
  int errors;

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] shamt;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_carry;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] sh, input logic [7:0] d);
    in_valid = v;
    in_op    = op;
    in_shamt = sh;
    in_data  = d;
  endtask

  task automatic check_vec(input string tag, input int i);
    check_eq({tag, "_valid"}, 8'(out_valid), 8'd1);
    check_eq({tag, "_data"}, out_data, vecs[i].exp_data);
    check_eq({tag, "_carry"}, 8'(out_carry), 8'(vecs[i].exp_carry));
    check_eq({tag, "_zero"}, 8'(out_zero), 8'(vecs[i].exp_data == 8'h00));
  endtask

  logic [7:0] bp_exp [6];
  logic       bub_pat [6];

  initial begin
    int sent;
    int rcv;
    int seen;
    logic [7:0] held;
    logic exp_v;

    checks = 0;
    errors = 0;

    vecs[0]  = '{3'd0, 3'd3, 8'hB4, 8'hA0, 1'b1};
    vecs[1]  = '{3'd1, 3'd3, 8'hB4, 8'h16, 1'b1};
    vecs[2]  = '{3'd2, 3'd3, 8'hB4, 8'hF6, 1'b1};
    vecs[3]  = '{3'd3, 3'd3, 8'hB4, 8'hA5, 1'b0};
    vecs[4]  = '{3'd4, 3'd3, 8'hB4, 8'h96, 1'b0};
    vecs[5]  = '{3'd7, 3'd3, 8'hB4, 8'hB4, 1'b0};
    vecs[6]  = '{3'd0, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[7]  = '{3'd1, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[8]  = '{3'd2, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[9]  = '{3'd3, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[10] = '{3'd4, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[11] = '{3'd1, 3'd1, 8'h01, 8'h00, 1'b1};
    vecs[12] = '{3'd2, 3'd7, 8'h80, 8'hFF, 1'b0};
    vecs[13] = '{3'd5, 3'd2, 8'h3C, 8'h3C, 1'b0};
    vecs[14] = '{3'd3, 3'd7, 8'h81, 8'hC0, 1'b0};

    bp_exp  = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C};
    bub_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with in_valid asserted
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 3'd3, 8'hB4);
    repeat (3) step();
    check_eq("rst_valid", 8'(out_valid), 8'd0);
    check_eq("rst_data", out_data, 8'h00);
    check_eq("rst_zero", 8'(out_zero), 8'd1);
    check_eq("rst_carry", 8'(out_carry), 8'd0);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 8'h00);
    #1;
    check_eq("rst_in_ready", 8'(in_ready), 8'd1);
    step();

    // First-accept latency: valid only after the third edge
    drive(1'b1, vecs[0].op, vecs[0].shamt, vecs[0].data);
    step();
    in_valid = 1'b0;
    check_eq("lat_edge1", 8'(out_valid), 8'd0);
    step();
    check_eq("lat_edge2", 8'(out_valid), 8'd0);
    step();
    check_vec("lat_edge3", 0);
    repeat (2) step();

    // Isolated table vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].shamt, vecs[i].data);
      step();
      in_valid = 1'b0;
      repeat (2) step();
      check_vec($sformatf("vec%0d", i), i);
      $display("vec %0d op=%0d shamt=%0d data=%02h -> out=%02h carry=%0d zero=%0d",
               i, vecs[i].op, vecs[i].shamt, vecs[i].data, out_data, out_carry, out_zero);
      step();
    end

    // Same table issued back-to-back: results on consecutive cycles, in order
    for (int c = 0; c < NVEC + 3; c++) begin
      if (c < NVEC) drive(1'b1, vecs[c].op, vecs[c].shamt, vecs[c].data);
      else          in_valid = 1'b0;
      #1;
      if (c >= 3) begin
        check_vec($sformatf("b2b%0d", c - 3), c - 3);
        $display("b2b %0d out=%02h carry=%0d", c - 3, out_data, out_carry);
      end
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Backpressure: 6 SLL-by-1 transactions, out_ready low for 4 cycles mid-stream
    sent = 0;
    rcv  = 0;
    held = 8'h00;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      out_ready = !(c >= 4 && c < 8);
      drive(sent < 6, 3'd0, 3'd1, 8'(sent + 1));
      #1;
      if (out_valid && !out_ready) begin
        check_eq("bp_in_ready", 8'(in_ready), 8'd0);
        if (c == 4) held = out_data;
        else        check_eq("bp_hold", out_data, held);
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("bp_data%0d", rcv), out_data, bp_exp[rcv]);
        $display("bp rcv %0d out=%02h", rcv, out_data);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check_eq("bp_count", 8'(rcv), 8'd6);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen++;
      step();
    end
    check_eq("bp_no_dup", 8'(seen), 8'd0);

    // Bubbles: alternating in_valid reappears with the same spacing three cycles later
    for (int c = 0; c < 10; c++) begin
      drive((c < 6) ? bub_pat[c] : 1'b0, 3'd0, 3'd0, 8'(c));
      #1;
      if (c >= 3) begin
        exp_v = (c - 3 < 6) ? bub_pat[c-3] : 1'b0;
        check_eq($sformatf("bub_valid%0d", c - 3), 8'(out_valid), 8'(exp_v));
        if (exp_v) check_eq($sformatf("bub_data%0d", c - 3), out_data, 8'(c - 3));
      end
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Mid-flight asynchronous reset with three transactions in the pipe
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 3'd0, 3'd0, 8'(8'h11 * (c + 1)));
      step();
    end
    in_valid = 1'b0;
    check_eq("mid_pre_valid", 8'(out_valid), 8'd1);
    check_eq("mid_pre_data", out_data, 8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 8'(out_valid), 8'd0);
    check_eq("mid_rst_data", out_data, 8'h00);
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("mid_no_emit", 8'(seen), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
